// File: rtl/fetch_sequencer.sv
// -----------------------------------------------------------------------------
// fetch_sequencer
//   Instruction-fetch end of the stall protocol for the 8-bit MIPS pipeline.
//   Owns PC sequencing, stall hold/replay, jump redirect with a two-cycle
//   bubble, and halt on a stalled HLT instruction.
//
//   Ports:
//     clk        in   clock, all state updates on posedge
//     reset      in   synchronous, active-high reset
//     Stall      in   hold PC (from stall controller)
//     Stall_pm   in   1 = replay held ins, 0 = load ins from pm_rdata
//     jump_en    in   taken jump/branch from execute
//     jump_addr  in   jump target
//     pm_rdata   in   program-memory read data (combinational from pm_addr)
//     pm_addr    out  program-memory address, equals pc
//     pc         out  current fetch address
//     ins        out  instruction register to decode / stall controller
//     ins_valid  out  1 = real instruction, 0 = bubble
//     halted     out  1 while in HALT
//     stall_cnt  out  saturating count of RUN stall cycles
//                     (only when FETCH_STALL_CNT_EN is defined)
//
//   Optional build macro: FETCH_STALL_CNT_EN
// -----------------------------------------------------------------------------
module fetch_sequencer #(
    parameter int                ADDR_W   = 8,
    parameter int                INS_W    = 24,
    parameter logic [INS_W-1:0]  NOP_WORD = 24'h000000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              Stall,
    input  logic              Stall_pm,
    input  logic              jump_en,
    input  logic [ADDR_W-1:0] jump_addr,
    input  logic [INS_W-1:0]  pm_rdata,
    output logic [ADDR_W-1:0] pm_addr,
    output logic [ADDR_W-1:0] pc,
    output logic [INS_W-1:0]  ins,
    output logic              ins_valid,
    output logic              halted
`ifdef FETCH_STALL_CNT_EN
    ,
    output logic [15:0]       stall_cnt
`endif
);

    typedef enum logic [1:0] {
        S_RUN   = 2'd0,
        S_FLUSH = 2'd1,
        S_HALT  = 2'd2
    } state_t;

    localparam logic [4:0] OP_HLT = 5'b10001;

    state_t              state_q;
    logic [ADDR_W-1:0]   pc_q;
    logic [INS_W-1:0]    ins_q;
    logic                vld_q;
    logic                halted_q;

    // Halt only on a real HLT word; a bubble never halts the machine.
    logic is_hlt;
    assign is_hlt = vld_q && (ins_q[INS_W-1 -: 5] == OP_HLT);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_RUN;
            pc_q     <= '0;
            ins_q    <= NOP_WORD;
            vld_q    <= 1'b0;
            halted_q <= 1'b0;
        end else begin
            unique case (state_q)
                S_RUN: begin
                    if (jump_en) begin
                        // Redirect beats stall and halt detection.
                        pc_q    <= jump_addr;
                        ins_q   <= NOP_WORD;
                        vld_q   <= 1'b0;
                        state_q <= S_FLUSH;
                    end else if (Stall && is_hlt) begin
                        state_q  <= S_HALT;
                        halted_q <= 1'b1;
                    end else if (Stall) begin
                        // Stall_pm=1 replays the held word; otherwise the
                        // word at the held PC is (re)loaded.
                        if (!Stall_pm) begin
                            ins_q <= pm_rdata;
                            vld_q <= 1'b1;
                        end
                    end else begin
                        pc_q  <= pc_q + ADDR_W'(1);
                        ins_q <= pm_rdata;
                        vld_q <= 1'b1;
                    end
                end
                S_FLUSH: begin
                    // Second bubble cycle; a back-to-back jump re-targets
                    // and buys one more flush cycle.
                    ins_q <= NOP_WORD;
                    vld_q <= 1'b0;
                    if (jump_en) begin
                        pc_q <= jump_addr;
                    end else begin
                        state_q <= S_RUN;
                    end
                end
                S_HALT: begin
                    // Frozen until reset.
                end
                default: state_q <= S_RUN;
            endcase
        end
    end

`ifdef FETCH_STALL_CNT_EN
    logic [15:0] cnt_q;
    logic [15:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (state_q == S_RUN && Stall && !jump_en && cnt_q != 16'hFFFF)
            cnt_d = cnt_q + 16'd1;
    end

    always_ff @(posedge clk) begin
        if (reset) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end

    assign stall_cnt = cnt_q;
`endif

    assign pc        = pc_q;
    assign pm_addr   = pc_q;
    assign ins       = ins_q;
    assign ins_valid = vld_q;
    assign halted    = halted_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
module tb_fetch_sequencer;

    localparam int M_RUN = 0, M_FLUSH = 1, M_HALT = 2;

    logic        clk = 1'b0;
    logic        reset, Stall, Stall_pm, jump_en;
    logic [7:0]  jump_addr;
    logic [23:0] pm_rdata;
    logic [7:0]  pm_addr, pc;
    logic [23:0] ins;
    logic        ins_valid, halted;
`ifdef FETCH_STALL_CNT_EN
    logic [15:0] stall_cnt;
`endif

    logic [23:0] mem [256];
    assign pm_rdata = mem[pm_addr];

    always #5 clk = ~clk;

    fetch_sequencer dut (
        .clk(clk), .reset(reset), .Stall(Stall), .Stall_pm(Stall_pm),
        .jump_en(jump_en), .jump_addr(jump_addr), .pm_rdata(pm_rdata),
        .pm_addr(pm_addr), .pc(pc), .ins(ins), .ins_valid(ins_valid),
        .halted(halted)
`ifdef FETCH_STALL_CNT_EN
        , .stall_cnt(stall_cnt)
`endif
    );

    int errors = 0;
    int checks = 0;

    // Reference model: architectural state stepped by the written rules.
    logic [7:0]  m_pc;
    logic [23:0] m_ins;
    logic        m_vld, m_halt;
    int          m_mode;
    int          m_cnt;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_step();
        logic [23:0] fetched;
        fetched = mem[m_pc];
        if (reset) begin
            m_pc = 0; m_ins = 0; m_vld = 0; m_halt = 0; m_mode = M_RUN; m_cnt = 0;
        end else if (m_mode == M_HALT) begin
            // nothing moves
        end else if (m_mode == M_FLUSH) begin
            m_ins = 0; m_vld = 0;
            if (jump_en) m_pc = jump_addr;
            else         m_mode = M_RUN;
        end else if (jump_en) begin
            m_pc = jump_addr; m_ins = 0; m_vld = 0; m_mode = M_FLUSH;
        end else if (Stall) begin
            if (m_cnt < 65535) m_cnt++;
            if (m_vld && m_ins[23:19] == 5'b10001) begin
                m_mode = M_HALT; m_halt = 1;
            end else if (!Stall_pm) begin
                m_ins = fetched; m_vld = 1;
            end
        end else begin
            m_ins = fetched; m_vld = 1; m_pc = m_pc + 8'd1;
        end
    endtask

    task automatic check_model();
        chk("pc", 32'(pc), 32'(m_pc));
        chk("pm_addr", 32'(pm_addr), 32'(m_pc));
        chk("ins", 32'(ins), 32'(m_ins));
        chk("ins_valid", 32'(ins_valid), 32'(m_vld));
        chk("halted", 32'(halted), 32'(m_halt));
`ifdef FETCH_STALL_CNT_EN
        chk("stall_cnt", 32'(stall_cnt), 32'(m_cnt));
`endif
    endtask

    task automatic tick(input logic r, input logic s, input logic sp,
                        input logic j, input logic [7:0] ja);
        reset = r; Stall = s; Stall_pm = sp; jump_en = j; jump_addr = ja;
        model_step();
        @(posedge clk);
        #1;
        check_model();
    endtask

    function automatic logic [23:0] word(input int i);
        return {5'b00001, 19'(i)};
    endfunction

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = word(i);
        m_pc = 8'hxx; m_ins = 'x; m_vld = 'x; m_halt = 'x; m_mode = M_RUN; m_cnt = 0;
        reset = 1; Stall = 0; Stall_pm = 0; jump_en = 0; jump_addr = 0;
        #2;

        // Reset state
        tick(1, 0, 0, 0, 0);
        tick(1, 0, 0, 0, 0);
        chk("rst_pc", 32'(pc), 0);
        chk("rst_ins", 32'(ins), 0);
        chk("rst_vld", 32'(ins_valid), 0);
        chk("rst_halted", 32'(halted), 0);

        // Sequential fetch
        tick(0, 0, 0, 0, 0);
        chk("seq_vld_c1", 32'(ins_valid), 1);
        chk("seq_ins_c1", 32'(ins), 32'(word(0)));
        for (int i = 0; i < 4; i++) tick(0, 0, 0, 0, 0);
        chk("seq_pc5", 32'(pc), 5);
        chk("seq_ins4", 32'(ins), 32'(word(4)));

        // Load stall at pc=3
        tick(1, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) tick(0, 0, 0, 0, 0);
        tick(0, 1, 0, 0, 0);
        chk("ldst_pc_a", 32'(pc), 3);
        chk("ldst_ins_a", 32'(ins), 32'(word(3)));
        tick(0, 1, 1, 0, 0);
        chk("ldst_pc_b", 32'(pc), 3);
        chk("ldst_ins_b", 32'(ins), 32'(word(3)));
        tick(0, 0, 0, 0, 0);
        chk("ldst_pc_rel", 32'(pc), 4);

        // Jump with simultaneous Stall at pc=7
        for (int i = 0; i < 3; i++) tick(0, 0, 0, 0, 0);
        chk("jmp_pc7", 32'(pc), 7);
        mem[8'h41] = {5'b10001, 19'h41};
        tick(0, 1, 0, 1, 8'h40);
        chk("jmp_pc", 32'(pc), 32'h40);
        chk("jmp_b1_ins", 32'(ins), 0);
        chk("jmp_b1_vld", 32'(ins_valid), 0);
        tick(0, 1, 0, 0, 0);
        chk("jmp_b2_pc", 32'(pc), 32'h40);
        chk("jmp_b2_vld", 32'(ins_valid), 0);
        tick(0, 0, 0, 0, 0);
        chk("jmp_ins40", 32'(ins), 32'(word(8'h40)));
        chk("jmp_vld3", 32'(ins_valid), 1);

        // Halt on stalled HLT, ignore jumps
        tick(0, 0, 0, 0, 0);
        tick(0, 1, 1, 0, 0);
        chk("hlt_halted", 32'(halted), 1);
        for (int i = 0; i < 10; i++) begin
            tick(0, 1'(i), 1'(i >> 1), 1'(i), 8'h10);
            chk("hlt_pc_frozen", 32'(pc), 32'h42);
        end
        tick(1, 0, 0, 0, 0);
        chk("hlt_rst_pc", 32'(pc), 0);
        chk("hlt_rst_halted", 32'(halted), 0);
        mem[8'h41] = word(8'h41);

        // Wrap
        tick(0, 0, 0, 1, 8'hFE);
        chk("wrap_fe_a", 32'(pc), 32'hFE);
        tick(0, 0, 0, 0, 0);
        chk("wrap_fe_b", 32'(pc), 32'hFE);
        tick(0, 0, 0, 0, 0);
        chk("wrap_ff", 32'(pc), 32'hFF);
        tick(0, 0, 0, 0, 0);
        chk("wrap_00", 32'(pc), 0);

        // Reset mid-FLUSH
        tick(0, 0, 0, 1, 8'h80);
        tick(1, 0, 0, 0, 0);
        chk("rstfl_pc", 32'(pc), 0);
        chk("rstfl_ins", 32'(ins), 0);
        tick(0, 0, 0, 0, 0);
        chk("rstfl_run", 32'(pc), 1);
        for (int i = 0; i < 4; i++) tick(0, 1, 1, 0, 0);
`ifdef FETCH_STALL_CNT_EN
        chk("stall_cnt4", 32'(stall_cnt), 4);
`endif

        // Randomized traffic against the model
        for (int i = 0; i < 256; i++)
            mem[i] = ($urandom_range(0, 15) == 0) ? {5'b10001, 19'($urandom)} : 24'($urandom);
        for (int n = 0; n < 3000; n++) begin
            tick(1'($urandom_range(0, 60) == 0),
                 1'($urandom_range(0, 2) == 0),
                 1'($urandom),
                 1'($urandom_range(0, 7) == 0),
                 8'($urandom));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
- Instruction-fetch end of the stall protocol: consumes Stall / Stall_pm from the stall controller and drives the PC, program-memory address and instruction register.
- The ins output feeds both decode and the stall controller, closing the loop.
- Sits between program memory and decode in the 8-bit MIPS pipeline; owns PC sequencing, stall hold/replay, jump redirect with bubble insertion, and halt.

Parameters:
- ADDR_W, 8, PC / program-memory address width.
- INS_W, 24, instruction width; opcode field is ins[INS_W-1:INS_W-5].
- NOP_WORD, 24'h000000, bubble word placed in ins on flush.

Ports:
- clk  in  1  clock; all state updates on posedge.
- reset  in  1  synchronous, active-high reset.
- Stall  in  1  from stall controller; hold PC.
- Stall_pm  in  1  from stall controller; 1 = replay held ins, 0 = load ins from pm_rdata.
- jump_en  in  1  taken jump/branch from execute.
- jump_addr  in  ADDR_W  jump target.
- pm_rdata  in  INS_W  program-memory read data; combinational from pm_addr, same cycle.
- pm_addr  out  ADDR_W  equals pc.
- pc  out  ADDR_W  current fetch address.
- ins  out  INS_W  instruction register to decode and stall controller.
- ins_valid  out  1  1 = ins is a real instruction, 0 = bubble.
- halted  out  1  1 while in HALT.

Behaviour:
- Reset (clk, synchronous, active-high): pc=0, ins=NOP_WORD, ins_valid=0, halted=0, state=RUN. Overrides everything, including from HALT or mid-FLUSH.
- Latency: ins/ins_valid reflect pm_rdata at pc one clock after pc is presented.
- States: RUN, FLUSH, HALT; 2-bit encoding.
- RUN, evaluated in priority order:
  1. jump_en=1: pc<=jump_addr; ins<=NOP_WORD; ins_valid<=0; next state FLUSH. Jump wins over Stall and the halt check.
  2. Stall=1 and ins opcode==5'b10001 (HLT) and ins_valid=1: pc and ins held; next state HALT.
  3. Stall=1: pc held. Stall_pm=1 -> ins and ins_valid held (replay). Stall_pm=0 -> ins<=pm_rdata, ins_valid<=1.
  4. Otherwise: pc<=pc+1, ins<=pm_rdata, ins_valid<=1.
- FLUSH (one cycle):
  - ins<=NOP_WORD, ins_valid<=0, pc held; Stall ignored; next state RUN.
  - jump_en=1 in FLUSH: pc<=jump_addr; stay FLUSH for one more cycle.
  - A jump therefore produces exactly 2 bubble cycles, matching the controller's 2-cycle jump stall.
- HALT: pc, ins and ins_valid frozen; halted=1; Stall, Stall_pm and jump_en ignored; exit only via reset.
- PC arithmetic: modulo 2^ADDR_W. For ADDR_W=8, 8'hFF+1 -> 8'h00, no flag.
- halted is registered: asserted the cycle state enters HALT, deasserted by reset.
- X-safety: Stall_pm is ignored when Stall=0; in that case ins always loads from pm_rdata.

Optional Feature:
- FETCH_STALL_CNT_EN defined: add output stall_cnt [15:0].
  - Counts RUN cycles with Stall=1 and jump_en=0.
  - Saturates at 16'hFFFF; frozen in HALT and FLUSH; reset to 0.
- Undefined: no port and no counter logic; all other behaviour identical.

Test Plan:
- Sequential fetch: memory word at addr i = {5'b00001, 19'(i)}; release reset, run 5 clocks -> pc=5; ins = word[4]; ins_valid=1 from cycle 1.
- Load stall: Stall=1, Stall_pm=0 for 1 cycle, then Stall=1, Stall_pm=1 for 1 cycle, with pc=3 -> pc stays 3 both cycles; ins loads word[3], then holds word[3]; pc=4 after release.
- Jump with simultaneous Stall: at pc=7, jump_en=1, jump_addr=8'h40, Stall=1 -> pc=8'h40; ins=NOP, ins_valid=0 for exactly 2 cycles; ins=word[0x40] on 3rd cycle.
- Halt: ins opcode 5'b10001 with Stall=1 -> halted=1 next cycle; pc frozen for 10 cycles despite jump_en pulses; reset -> pc=0, halted=0.
- Wrap: jump to 8'hFE, run 3 cycles with no stall -> pc sequence FE, FE (flush), FF, 00.
- Reset mid-FLUSH: assert reset the cycle after jump_en -> pc=0, ins=NOP, state RUN. With FETCH_STALL_CNT_EN, 4 RUN stall cycles -> stall_cnt=4.
